hexdisp_scan: RTL
=================

HEXDISP_SCAN -- requirements
Module: hexdisp_scan

Interface
REQ-001 SHALL have parameters: NDIGITS, default 8, number of multiplexed digits (1..8).
REQ-002 SHALL have parameters: TICK_DIV, default 50000, clk_i cycles per digit slot (>=2*GAP_CYC).
REQ-003 SHALL have parameters: GAP_CYC, default 16, anode-off cycles at the start of each slot.
REQ-004 SHALL have ports: clk_i  in  1  system clock; one clock domain.
REQ-005 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: cyc_i, stb_i, we_i  in  1 each  bus cycle, strobe, write.
REQ-007 SHALL have ports: adr_i  in  2  word address; sel_i  in  4  byte lanes; dat_i  in  32  write data.
REQ-008 SHALL have ports: dat_o  out  32  read data; ack_o  out  1  transfer acknowledge.
REQ-009 SHALL have ports: seg_o  out  7  active-low segments g..a; dp_o  out  1  active-low decimal point.
REQ-010 SHALL have ports: an_o  out  NDIGITS  active-low digit enables.

Function
REQ-011 SHALL decode registers: adr 0 VALUE[31:0] (nibble i = digit i); adr 1 CTRL: bit0 EN, [15:8] BLANK mask, [23:16] DP mask; adr 2 STATUS (RO): [2:0] current digit, bit8 frame-done sticky (write 1 clears); adr 3 reads 0, writes ignored.
REQ-012 SHALL assert ack_o exactly one cycle after cyc_i&stb_i&!ack_o; ack_o then deasserts for at least one cycle; dat_o valid with ack_o.
REQ-013 SHALL apply writes per sel_i byte lane only; unselected bytes unchanged.
REQ-014 SHALL copy VALUE, BLANK and DP masks into shadow registers only at frame start (digit index 0 entering GAP) — no tearing mid-frame.
REQ-015 SHALL run states IDLE, GAP, DRIVE: IDLE while EN=0 (an_o all 1); EN 0->1 enters GAP with digit 0 and loads shadow; GAP lasts GAP_CYC cycles with an_o all 1; DRIVE lasts TICK_DIV-GAP_CYC cycles with an_o[d]=0.
REQ-016 SHALL, at end of DRIVE, advance digit d to (d+1) mod NDIGITS and enter GAP; wrap to 0 sets frame-done.
REQ-017 SHALL, when EN cleared mid-slot, go to IDLE on the next cycle, an_o all 1, digit index reset to 0.
REQ-018 SHALL drive seg_o with the hex 7-segment pattern of shadow nibble d (0=1000000 ... F=0001110) during DRIVE; all 1 in GAP/IDLE or when BLANK[d]=1.
REQ-019 SHALL drive dp_o = ~DP[d] in DRIVE, 1 otherwise.
REQ-020 SHALL register seg_o, dp_o, an_o (one-cycle latency from state/index to pins); segments and anodes change in the same cycle.
REQ-021 SHALL give a same-cycle frame-done set and write-1-clear precedence to set.

Reset
REQ-022 SHALL, on rst_n low, immediately force: seg_o=7'h7F, dp_o=1, an_o all 1, ack_o=0, dat_o=0, state IDLE, digit 0, counters 0, VALUE=0, CTRL=0, shadows 0, frame-done 0.
REQ-023 SHALL release reset synchronously to clk_i edge-free (asynchronous assert, first state update on the first clk_i edge after deassert).

Configuration
REQ-024 SHALL implement leading-zero blanking under macro HEXDISP_SCAN_LZB_EN: with it defined, digits above the most significant nonzero shadow nibble are blanked (digit 0 always shown, value 0 shows single "0"), OR-ed with BLANK; without it, only BLANK applies and the logic is absent.

Structure
REQ-025 SHALL place register address constants, CTRL/STATUS bit positions and the state enum in shared package hexdisp_scan_pkg.
REQ-026 SHALL instantiate the existing combinational sub-module hexdisp for nibble-to-segment decode; no other sub-modules.

Verification
REQ-027 SHALL test: TICK_DIV=40, GAP_CYC=4, VALUE=0x12345678, EN=1 -> an_o walks digits 0..7, each low 36 cycles after 4 gap cycles; digit 0 seg_o=0000000 ("8"), digit 7 seg_o=1111001 ("1").
REQ-028 SHALL test: write VALUE=0xFFFFFFFF mid-frame -> current frame keeps old value; next frame digit 0 shows 0001110.
REQ-029 SHALL test: sel_i=4'b0010, dat_i=0xAABBCCDD to VALUE=0 -> readback 0x0000CC00; ack_o one cycle, not back-to-back.
REQ-030 SHALL test: EN cleared during DRIVE of digit 3 -> next cycle IDLE, an_o all 1 after one register stage; re-enable starts at digit 0.
REQ-031 SHALL test: LZB_EN defined, VALUE=0x00000A05 -> digits 3..7 blanked, digits 0..2 show 5,0,A; undefined -> all eight driven.
REQ-032 SHALL test: rst_n low during DRIVE -> an_o all 1 and seg_o=7F without a clock edge; frame-done read 1 then cleared by write 1.

Source files
------------

// File: rtl/hexdisp_scan_pkg.sv
// Shared definitions for the hexdisp_scan multiplexed 7-segment display controller:
// register map, CTRL/STATUS field positions and the scan state encoding.
package hexdisp_scan_pkg;

    localparam logic [1:0] ADR_VALUE  = 2'd0;
    localparam logic [1:0] ADR_CTRL   = 2'd1;
    localparam logic [1:0] ADR_STATUS = 2'd2;
    localparam logic [1:0] ADR_RSVD   = 2'd3;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_BLANK_LSB   = 8;
    localparam int CTRL_DP_LSB      = 16;
    localparam int STATUS_DIGIT_LSB = 0;
    localparam int STATUS_FDONE_BIT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

endpackage

// File: rtl/hexdisp.sv
// Combinational hex nibble to active-low 7-segment decoder, segment order g..a.
module hexdisp (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (nibble_i)
            4'h0:    seg_o = 7'b1000000;
            4'h1:    seg_o = 7'b1111001;
            4'h2:    seg_o = 7'b0100100;
            4'h3:    seg_o = 7'b0110000;
            4'h4:    seg_o = 7'b0011001;
            4'h5:    seg_o = 7'b0010010;
            4'h6:    seg_o = 7'b0000010;
            4'h7:    seg_o = 7'b1111000;
            4'h8:    seg_o = 7'b0000000;
            4'h9:    seg_o = 7'b0010000;
            4'hA:    seg_o = 7'b0001000;
            4'hB:    seg_o = 7'b0000011;
            4'hC:    seg_o = 7'b1000110;
            4'hD:    seg_o = 7'b0100001;
            4'hE:    seg_o = 7'b0000110;
            default: seg_o = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/hexdisp_scan.sv
// Bus-programmable multiplexed hex display scanner with per-slot anode-off gap.
// Optional leading-zero blanking is built when HEXDISP_SCAN_LZB_EN is defined.
module hexdisp_scan
    import hexdisp_scan_pkg::*;
#(
    parameter int NDIGITS  = 8,
    parameter int TICK_DIV = 50000,
    parameter int GAP_CYC  = 16
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               cyc_i,
    input  logic               stb_i,
    input  logic               we_i,
    input  logic [1:0]         adr_i,
    input  logic [3:0]         sel_i,
    input  logic [31:0]        dat_i,
    output logic [31:0]        dat_o,
    output logic               ack_o,
    output logic [6:0]         seg_o,
    output logic               dp_o,
    output logic [NDIGITS-1:0] an_o
);

    localparam int               CNT_W      = $clog2(TICK_DIV + 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(TICK_DIV - GAP_CYC - 1);
    localparam logic [2:0]       DIGIT_LAST = 3'(NDIGITS - 1);

    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;
    logic [31:0]        value_q, value_d;
    logic               en_q, en_d;
    logic [7:0]         blank_q, blank_d;
    logic [7:0]         dpm_q, dpm_d;
    logic               fdone_q, fdone_d;
    state_e             state_q, state_d;
    logic [2:0]         digit_q, digit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        sh_value_q, sh_value_d;
    logic [7:0]         sh_blank_q, sh_blank_d;
    logic [7:0]         sh_dp_q, sh_dp_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [NDIGITS-1:0] an_q, an_d;

    logic       req, wr, fdone_clr, load_shadow, lzb_blank, blank_now;
    logic [3:0] nibble;
    logic [6:0] hex_seg;

    assign req       = cyc_i & stb_i & ~ack_q;
    assign wr        = req & we_i;
    assign fdone_clr = wr && (adr_i == ADR_STATUS) && sel_i[1] && dat_i[STATUS_FDONE_BIT];

    always_comb begin
        ack_d   = req;
        dat_d   = '0;
        value_d = value_q;
        en_d    = en_q;
        blank_d = blank_q;
        dpm_d   = dpm_q;
        if (wr) begin
            case (adr_i)
                ADR_VALUE: begin
                    for (int b = 0; b < 4; b++)
                        if (sel_i[b]) value_d[8*b +: 8] = dat_i[8*b +: 8];
                end
                ADR_CTRL: begin
                    if (sel_i[0]) en_d    = dat_i[CTRL_EN_BIT];
                    if (sel_i[1]) blank_d = dat_i[CTRL_BLANK_LSB +: 8];
                    if (sel_i[2]) dpm_d   = dat_i[CTRL_DP_LSB +: 8];
                end
                ADR_STATUS: ;
                ADR_RSVD:   ;
                default:    ;
            endcase
        end
        if (req && !we_i) begin
            case (adr_i)
                ADR_VALUE:  dat_d = value_q;
                ADR_CTRL:   dat_d = {8'h00, dpm_q, blank_q, 7'h00, en_q};
                ADR_STATUS: dat_d = {23'h0, fdone_q, 5'h00, digit_q};
                default:    dat_d = '0;
            endcase
        end
    end

    // Shadows are only reloaded when digit 0 enters its gap, so a frame never mixes old and new data.
    always_comb begin
        state_d     = state_q;
        digit_d     = digit_q;
        cnt_d       = cnt_q;
        fdone_d     = fdone_q;
        load_shadow = 1'b0;
        if (fdone_clr) fdone_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                digit_d = '0;
                cnt_d   = '0;
                if (en_q) begin
                    state_d     = ST_GAP;
                    load_shadow = 1'b1;
                end
            end
            ST_GAP: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                    digit_d = '0;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRIVE: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                    digit_d = '0;
                    cnt_d   = '0;
                end else if (cnt_q == DRIVE_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    if (digit_q == DIGIT_LAST) begin
                        digit_d     = '0;
                        load_shadow = 1'b1;
                        fdone_d     = 1'b1;
                    end else begin
                        digit_d = digit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                digit_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        sh_value_d = sh_value_q;
        sh_blank_d = sh_blank_q;
        sh_dp_d    = sh_dp_q;
        if (load_shadow) begin
            sh_value_d = value_q;
            sh_blank_d = blank_q;
            sh_dp_d    = dpm_q;
        end
    end

    assign nibble = sh_value_q[{digit_q, 2'b00} +: 4];

    hexdisp u_hexdisp (
        .nibble_i (nibble),
        .seg_o    (hex_seg)
    );

`ifdef HEXDISP_SCAN_LZB_EN
    logic [2:0] msd;

    // Digit 0 is never blanked because msd bottoms out at 0 even for an all-zero value.
    always_comb begin
        msd = '0;
        for (int i = 0; i < NDIGITS; i++)
            if (sh_value_q[4*i +: 4] != 4'h0) msd = 3'(i);
    end
    assign lzb_blank = (digit_q > msd);
`else
    assign lzb_blank = 1'b0;
`endif

    assign blank_now = sh_blank_q[digit_q] | lzb_blank;

    always_comb begin
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        an_d  = '1;
        if (state_q == ST_DRIVE) begin
            for (int i = 0; i < NDIGITS; i++)
                an_d[i] = (digit_q != 3'(i));
            if (!blank_now) seg_d = hex_seg;
            dp_d = ~sh_dp_q[digit_q];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            value_q    <= '0;
            en_q       <= 1'b0;
            blank_q    <= '0;
            dpm_q      <= '0;
            fdone_q    <= 1'b0;
            state_q    <= ST_IDLE;
            digit_q    <= '0;
            cnt_q      <= '0;
            sh_value_q <= '0;
            sh_blank_q <= '0;
            sh_dp_q    <= '0;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            an_q       <= '1;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            value_q    <= value_d;
            en_q       <= en_d;
            blank_q    <= blank_d;
            dpm_q      <= dpm_d;
            fdone_q    <= fdone_d;
            state_q    <= state_d;
            digit_q    <= digit_d;
            cnt_q      <= cnt_d;
            sh_value_q <= sh_value_d;
            sh_blank_q <= sh_blank_d;
            sh_dp_q    <= sh_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;
    assign seg_o = seg_q;
    assign dp_o  = dp_q;
    assign an_o  = an_q;

endmodule
